// File: rtl/vend_pkg.sv
// Shared definitions for the vending engine.
// Contents:
//   vend_state_t  - FSM encoding, also driven on the top-level state port
//   COIN_*        - accepted coin denominations, also used as change coins
//   next_coin()   - largest denomination not exceeding a value (0 for 0)
//   is_legal_coin - true for an acceptable inserted coin
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_t;

    localparam int unsigned COIN_1  = 1;
    localparam int unsigned COIN_5  = 5;
    localparam int unsigned COIN_10 = 10;
    localparam int unsigned COIN_50 = 50;

    function automatic int unsigned next_coin(input int unsigned value);
        if (value >= COIN_50)      return COIN_50;
        else if (value >= COIN_10) return COIN_10;
        else if (value >= COIN_5)  return COIN_5;
        else if (value >= COIN_1)  return COIN_1;
        else                       return 0;
    endfunction

    function automatic logic is_legal_coin(input int unsigned value);
        return (value == COIN_1) || (value == COIN_5) ||
               (value == COIN_10) || (value == COIN_50);
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Change dispenser: loads an amount, then presents one greedy coin per
// cycle until the amount is exhausted.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   i_load            - load i_load_value (must be non-zero)
//   i_load_value      - amount of change to return
//   o_coin            - coin presented this cycle (0 when idle)
//   o_coin_valid      - o_coin is a real coin this cycle
//   o_remaining       - amount still owed after the coin now presented
//   o_done            - the coin now presented is the last one
module change_dispenser
    import vend_pkg::*;
#(
    parameter int MONEY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [MONEY_W-1:0] i_load_value,
    output logic [MONEY_W-1:0] o_coin,
    output logic               o_coin_valid,
    output logic [MONEY_W-1:0] o_remaining,
    output logic               o_done
);

    logic [MONEY_W-1:0] r_coin;
    logic [MONEY_W-1:0] r_rem;
    logic               r_valid;
    logic [MONEY_W-1:0] w_src;
    logic [MONEY_W-1:0] w_next_coin;

    // The coin for the next cycle is taken from the freshly loaded amount
    // or from what is still owed after the coin presented now.
    always_comb begin
        w_src       = i_load ? i_load_value : r_rem;
        w_next_coin = MONEY_W'(next_coin(32'(w_src)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_coin  <= '0;
            r_rem   <= '0;
            r_valid <= 1'b0;
        end else if (i_load || (r_valid && (r_rem != '0))) begin
            r_coin  <= w_next_coin;
            r_rem   <= w_src - w_next_coin;
            r_valid <= 1'b1;
        end else begin
            r_coin  <= '0;
            r_rem   <= '0;
            r_valid <= 1'b0;
        end
    end

    assign o_coin       = r_coin;
    assign o_coin_valid = r_valid;
    assign o_remaining  = r_rem;
    assign o_done       = r_valid && (r_rem == '0);

endmodule

// File: rtl/vending_engine.sv
// Vending engine: accepts coins, sells drinks from a fixed price table,
// tracks per-drink stock and returns change one coin per cycle.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   coin_valid, coin_value     - inserted coin strobe and value
//   select                     - requested drink ID (0 = none)
//   cancel                     - refund request
//   restock                    - reload every stock counter (IDLE only)
//   total_money                - credit, or change still owed in CHANGE
//   state                      - IDLE=0, CREDIT=1, VEND=2, CHANGE=3
//   drink_out, drink_valid     - dispensed drink, valid for the VEND cycle
//   change_coin, change_valid  - one returned coin per CHANGE cycle
//   coin_reject, select_nak    - one-cycle refusal pulses
//   sold_out                   - bit i-1 high while drink i has no stock
// Strobe semantics: there is no back-pressure. Every input is sampled on
// each rising edge; every *_valid/pulse output is high for exactly the one
// cycle its value is meaningful and its data output is 0 otherwise.
module vending_engine
    import vend_pkg::*;
#(
    parameter int NUM_DRINKS = 4,
    parameter int MONEY_W    = 8,
    parameter logic [NUM_DRINKS*MONEY_W-1:0] PRICE_TABLE = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int MAX_CREDIT = 200,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5,
    localparam int SEL_W     = $clog2(NUM_DRINKS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  coin_valid,
    input  logic [MONEY_W-1:0]    coin_value,
    input  logic [SEL_W-1:0]      select,
    input  logic                  cancel,
    input  logic                  restock,
    output logic [MONEY_W-1:0]    total_money,
    output logic [1:0]            state,
    output logic [SEL_W-1:0]      drink_out,
    output logic                  drink_valid,
    output logic [MONEY_W-1:0]    change_coin,
    output logic                  change_valid,
    output logic                  coin_reject,
    output logic                  select_nak,
    output logic [NUM_DRINKS-1:0] sold_out
);

    function automatic logic [MONEY_W-1:0] f_min_price();
        logic [MONEY_W-1:0] m;
        m = PRICE_TABLE[MONEY_W-1:0];
        for (int i = 1; i < NUM_DRINKS; i++) begin
            if (PRICE_TABLE[i*MONEY_W +: MONEY_W] < m) m = PRICE_TABLE[i*MONEY_W +: MONEY_W];
        end
        return m;
    endfunction

    localparam logic [MONEY_W-1:0] MIN_PRICE = f_min_price();

    vend_state_t           r_state;
    logic [MONEY_W-1:0]    r_total;
    logic [STOCK_W-1:0]    r_stock [NUM_DRINKS];
    logic [NUM_DRINKS-1:0] r_sold_out;
    logic [SEL_W-1:0]      r_drink_out;
    logic                  r_drink_valid;
    logic                  r_coin_reject;
    logic                  r_select_nak;

    logic [SEL_W-1:0]   w_idx;
    logic [MONEY_W-1:0] w_price;
    logic               w_in_stock;
    logic               w_open;
    logic [MONEY_W:0]   w_sum;
    logic               w_cancel_go;
    logic               w_coin_ok;
    logic               w_can_vend;
    logic [MONEY_W-1:0] w_vend_rem;
    logic               w_load;
    logic [MONEY_W-1:0] w_load_value;
    logic [MONEY_W-1:0] w_disp_rem;
    logic               w_disp_done;

    // In VEND the lookup follows the drink being sold, otherwise the request.
    // An out-of-range ID matches no slot and therefore reads as out of stock.
    always_comb begin
        w_idx      = (r_state == ST_VEND) ? r_drink_out : select;
        w_price    = '0;
        w_in_stock = 1'b0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (w_idx == SEL_W'(i + 1)) begin
                w_price    = PRICE_TABLE[i*MONEY_W +: MONEY_W];
                w_in_stock = (r_stock[i] != '0);
            end
        end
        w_open       = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
        w_sum        = {1'b0, r_total} + {1'b0, coin_value};
        w_cancel_go  = w_open && cancel && (r_total != '0);
        // A cancel in the same cycle always bounces the coin.
        w_coin_ok    = coin_valid && w_open && !cancel && is_legal_coin(32'(coin_value)) &&
                       (w_sum <= (MONEY_W+1)'(MAX_CREDIT));
        // Affordability uses the pre-coin credit.
        w_can_vend   = (r_state == ST_CREDIT) && (r_total >= w_price) && w_in_stock;
        w_vend_rem   = r_total - w_price;
        w_load       = w_cancel_go || ((r_state == ST_VEND) && (w_vend_rem != '0));
        w_load_value = (r_state == ST_VEND) ? w_vend_rem : r_total;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_total       <= '0;
            r_sold_out    <= '0;
            r_drink_out   <= '0;
            r_drink_valid <= 1'b0;
            r_coin_reject <= 1'b0;
            r_select_nak  <= 1'b0;
            for (int i = 0; i < NUM_DRINKS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            r_drink_out   <= '0;
            r_drink_valid <= 1'b0;
            r_select_nak  <= 1'b0;
            r_coin_reject <= coin_valid && !w_coin_ok;
            case (r_state)
                ST_IDLE, ST_CREDIT: begin
                    if (w_cancel_go) begin
                        r_state <= ST_CHANGE;
                    end else begin
                        if (w_coin_ok) r_total <= w_sum[MONEY_W-1:0];
                        if ((select != '0) && !cancel) begin
                            if (w_can_vend) begin
                                r_state       <= ST_VEND;
                                r_drink_out   <= select;
                                r_drink_valid <= 1'b1;
                            end else begin
                                r_select_nak <= 1'b1;
                            end
                        end
                        if ((r_state == ST_IDLE) && w_coin_ok && (w_sum >= {1'b0, MIN_PRICE}))
                            r_state <= ST_CREDIT;
                    end
                    if ((r_state == ST_IDLE) && restock) begin
                        r_sold_out <= '0;
                        for (int i = 0; i < NUM_DRINKS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
                    end
                end
                ST_VEND: begin
                    r_total <= w_vend_rem;
                    for (int i = 0; i < NUM_DRINKS; i++) begin
                        if (r_drink_out == SEL_W'(i + 1)) begin
                            r_stock[i]    <= r_stock[i] - 1'b1;
                            r_sold_out[i] <= (r_stock[i] == STOCK_W'(1));
                        end
                    end
                    r_state <= (w_vend_rem != '0) ? ST_CHANGE : ST_IDLE;
                end
                ST_CHANGE: begin
                    // The displayed total tracks what is owed including the
                    // coin currently on change_coin.
                    r_total <= w_disp_rem;
                    if (w_disp_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    change_dispenser #(.MONEY_W(MONEY_W)) u_change (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .o_coin       (change_coin),
        .o_coin_valid (change_valid),
        .o_remaining  (w_disp_rem),
        .o_done       (w_disp_done)
    );

    assign total_money = r_total;
    assign state       = r_state;
    assign drink_out   = r_drink_out;
    assign drink_valid = r_drink_valid;
    assign coin_reject = r_coin_reject;
    assign select_nak  = r_select_nak;
    assign sold_out    = r_sold_out;

endmodule

// File: tb/tb_vending_engine.sv
module tb_vending_engine;

    localparam int ND = 4;
    localparam int MW = 8;
    localparam int SW = 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          coin_valid = 1'b0;
    logic [MW-1:0] coin_value = '0;
    logic [SW-1:0] select = '0;
    logic          cancel = 1'b0;
    logic          restock = 1'b0;

    logic [MW-1:0] total_money;
    logic [1:0]    state;
    logic [SW-1:0] drink_out;
    logic          drink_valid;
    logic [MW-1:0] change_coin;
    logic          change_valid;
    logic          coin_reject;
    logic          select_nak;
    logic [ND-1:0] sold_out;

    always #5 clk = ~clk;

    vending_engine dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .select       (select),
        .cancel       (cancel),
        .restock      (restock),
        .total_money  (total_money),
        .state        (state),
        .drink_out    (drink_out),
        .drink_valid  (drink_valid),
        .change_coin  (change_coin),
        .change_valid (change_valid),
        .coin_reject  (coin_reject),
        .select_nak   (select_nak),
        .sold_out     (sold_out)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Prices of drinks 1..4, minimum price, and change as a queue of coins.
    int prices [ND] = '{10, 15, 20, 25};
    int m_state, m_total, m_vend_id;
    int m_stock [ND];
    logic [MW-1:0] exp_q[$];
    int e_drink_valid, e_drink_out, e_coin_reject, e_select_nak, e_change_valid, e_change_coin;

    function automatic int min_price();
        int m = prices[0];
        foreach (prices[i]) if (prices[i] < m) m = prices[i];
        return m;
    endfunction

    function automatic bit legal_coin(input int v);
        return (v == 1) || (v == 5) || (v == 10) || (v == 50);
    endfunction

    function automatic logic [ND-1:0] exp_sold_out();
        logic [ND-1:0] v;
        for (int i = 0; i < ND; i++) v[i] = (m_stock[i] == 0);
        return v;
    endfunction

    task automatic load_change(input int amount);
        int denoms [4] = '{50, 10, 5, 1};
        int rest = amount;
        exp_q.delete();
        foreach (denoms[k]) begin
            while (rest >= denoms[k]) begin
                exp_q.push_back(MW'(denoms[k]));
                rest -= denoms[k];
            end
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_total = 0; m_vend_id = 0;
        for (int i = 0; i < ND; i++) m_stock[i] = 5;
        exp_q.delete();
        e_drink_valid = 0; e_drink_out = 0; e_coin_reject = 0;
        e_select_nak = 0; e_change_valid = 0; e_change_coin = 0;
    endtask

    task automatic model_step();
        int old_state = m_state;
        int sel = int'(select);
        int cv = int'(coin_value);
        bit take;
        e_drink_valid = 0; e_drink_out = 0; e_select_nak = 0;
        e_coin_reject = int'(coin_valid);
        if (old_state == 0 || old_state == 1) begin
            if (cancel && m_total > 0) begin
                m_state = 3;
                load_change(m_total);
            end else begin
                take = coin_valid && !cancel && legal_coin(cv) && (m_total + cv <= 200);
                if (take) e_coin_reject = 0;
                if (sel != 0 && !cancel) begin
                    if (old_state == 1 && sel <= ND && m_total >= prices[sel-1] && m_stock[sel-1] > 0) begin
                        m_state = 2; m_vend_id = sel;
                        e_drink_valid = 1; e_drink_out = sel;
                    end else begin
                        e_select_nak = 1;
                    end
                end
                if (take) m_total += cv;
                if (m_state == 0 && m_total >= min_price()) m_state = 1;
            end
            if (old_state == 0 && restock) for (int i = 0; i < ND; i++) m_stock[i] = 5;
        end else if (old_state == 2) begin
            m_total -= prices[m_vend_id-1];
            m_stock[m_vend_id-1]--;
            if (m_total > 0) begin
                m_state = 3;
                load_change(m_total);
            end else begin
                m_state = 0;
            end
        end else begin
            void'(exp_q.pop_front());
            m_total = 0;
            foreach (exp_q[k]) m_total += int'(exp_q[k]);
            if (exp_q.size() == 0) m_state = 0;
        end
        e_change_valid = (m_state == 3) ? 1 : 0;
        e_change_coin  = (m_state == 3) ? int'(exp_q[0]) : 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("state", 32'(state), 32'(m_state));
            check("total_money", 32'(total_money), 32'(m_total));
            check("drink_valid", 32'(drink_valid), 32'(e_drink_valid));
            check("drink_out", 32'(drink_out), 32'(e_drink_out));
            check("change_valid", 32'(change_valid), 32'(e_change_valid));
            check("change_coin", 32'(change_coin), 32'(e_change_coin));
            check("coin_reject", 32'(coin_reject), 32'(e_coin_reject));
            check("select_nak", 32'(select_nak), 32'(e_select_nak));
            check("sold_out", 32'(sold_out), 32'(exp_sold_out()));
        end
    end

    // ---------------- driver ----------------
    // Drives one cycle of inputs, returns just after the consuming edge.
    task automatic step(input bit cv, input int val, input int sel, input bit can, input bit rst);
        @(negedge clk); #1;
        coin_valid = cv;
        coin_value = MW'(val);
        select     = SW'(sel);
        cancel     = can;
        restock    = rst;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    int chg_lit [6] = '{50, 50, 50, 10, 10, 10};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("reset_state", 32'(state), 0);
        check("reset_total", 32'(total_money), 0);
        check("reset_sold_out", 32'(sold_out), 0);
        check("reset_change_valid", 32'(change_valid), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        idle();

        // credit build-up, early select refused, then a sale with change
        step(1, 10, 0, 0, 0);
        check("credit10_state", 32'(state), 1);
        step(1, 5, 0, 0, 0);
        step(1, 10, 4, 0, 0);
        check("early_sel_nak", 32'(select_nak), 1);
        check("early_sel_total", 32'(total_money), 25);
        step(1, 10, 0, 0, 0);
        check("total35", 32'(total_money), 35);
        step(0, 0, 4, 0, 0);
        check("vend_valid", 32'(drink_valid), 1);
        check("vend_id", 32'(drink_out), 4);
        check("vend_state", 32'(state), 2);
        idle();
        check("chg10_coin", 32'(change_coin), 10);
        check("chg10_state", 32'(state), 3);
        idle();
        check("after_chg_state", 32'(state), 0);
        check("after_chg_total", 32'(total_money), 0);

        // cancel refund and illegal coin
        step(1, 50, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("cancel_coin", 32'(change_coin), 50);
        idle();
        check("cancel_total", 32'(total_money), 0);
        step(1, 5, 0, 0, 0);
        check("low_credit_state", 32'(state), 0);
        step(1, 7, 0, 0, 0);
        check("coin7_reject", 32'(coin_reject), 1);
        check("coin7_total", 32'(total_money), 5);
        step(0, 0, 0, 1, 0);
        idle();

        // sell drink 1 out, refusal, ignored and honoured restock
        for (int i = 0; i < 5; i++) begin
            step(1, 10, 0, 0, 0);
            step(0, 0, 1, 0, 0);
            idle();
        end
        check("sold_out_d1", 32'(sold_out), 1);
        step(1, 10, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        check("sold_out_nak", 32'(select_nak), 1);
        check("restock_ignored", 32'(sold_out), 1);
        step(0, 0, 0, 1, 0);
        idle();
        step(0, 0, 0, 0, 1);
        check("restock_idle", 32'(sold_out), 0);

        // credit ceiling and long change sequence
        repeat (4) step(1, 50, 0, 0, 0);
        check("total200", 32'(total_money), 200);
        step(1, 1, 0, 0, 0);
        check("over_max_reject", 32'(coin_reject), 1);
        check("over_max_total", 32'(total_money), 200);
        step(0, 0, 3, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(k == 1, 10, 0, 0, 0);
            check("chg180_coin", 32'(change_coin), 32'(chg_lit[k]));
            if (k == 1) check("chg_coin_reject", 32'(coin_reject), 1);
        end
        idle();
        check("chg180_done", 32'(state), 0);

        // select evaluated on pre-coin credit, coin still accepted
        step(1, 10, 0, 0, 0);
        step(1, 10, 2, 0, 0);
        check("same_cycle_nak", 32'(select_nak), 1);
        check("same_cycle_total", 32'(total_money), 20);
        step(0, 0, 2, 0, 0);
        idle();
        check("chg5_coin", 32'(change_coin), 5);
        idle();

        // reset during CHANGE
        step(1, 50, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 2, 0, 0);
        idle();
        check("pre_reset_total", 32'(total_money), 36);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(state), 0);
        check("async_reset_total", 32'(total_money), 0);
        check("async_reset_chg", 32'(change_valid), 0);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (3) idle();
        check("post_reset_chg", 32'(change_valid), 0);
        check("post_reset_state", 32'(state), 0);
        repeat (2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vending_engine.md
VENDING_ENGINE -- requirements
Module: vending_engine

Interface
REQ-001 Parameter NUM_DRINKS, default 4, number of drink slots (2..15); drink IDs 1..NUM_DRINKS, ID 0 = none.
REQ-002 Parameter MONEY_W, default 8, width of all money values.
REQ-003 Parameter PRICE_TABLE, default {25,20,15,10}, packed NUM_DRINKS*MONEY_W price list; slice i-1 is the price of drink i.
REQ-004 Parameter MAX_CREDIT, default 200, highest total_money the block shall hold.
REQ-005 Parameter STOCK_W, default 4, width of each per-drink stock counter.
REQ-006 Parameter INIT_STOCK, default 5, stock loaded into every slot at reset and on restock.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 coin_valid  in  1  coin_value is presented this cycle.
REQ-010 coin_value  in  MONEY_W  inserted coin; legal denominations are 1, 5, 10 and 50.
REQ-011 select  in  SEL_W=$clog2(NUM_DRINKS+1)  requested drink ID; 0 = no request.
REQ-012 cancel  in  1  refund request.
REQ-013 restock  in  1  reload all stock counters to INIT_STOCK.
REQ-014 total_money  out  MONEY_W  current credit, or remaining change while dispensing.
REQ-015 state  out  2  FSM state: IDLE=0, CREDIT=1, VEND=2, CHANGE=3.
REQ-016 drink_out / drink_valid  out  SEL_W / 1  dispensed drink ID, with its one-cycle strobe.
REQ-017 change_coin / change_valid  out  MONEY_W / 1  one returned coin per cycle, with its strobe.
REQ-018 coin_reject / select_nak  out  1 / 1  one-cycle pulses: coin returned unaccepted; selection refused.
REQ-019 sold_out  out  NUM_DRINKS  bit i-1 is high while the stock of drink i is 0.

Function
REQ-020 All outputs are registered; every pulse output lasts exactly one cycle and is 0 otherwise.
REQ-021 A coin is accepted only in IDLE or CREDIT, only with a legal denomination, and only when total_money+coin_value <= MAX_CREDIT; otherwise coin_reject pulses the next cycle and total is unchanged.
REQ-022 IDLE -> CREDIT when the post-coin total >= min(PRICE_TABLE); the minimum is computed at elaboration.
REQ-023 In CREDIT, if select != 0 and cancel = 0: when total >= price(select) and the stock of that drink > 0 -> VEND; otherwise select_nak pulses and the state stays CREDIT.
REQ-024 A select is evaluated against the pre-coin total; a coin arriving in the same cycle is still accepted.
REQ-025 A select value greater than NUM_DRINKS raises select_nak.
REQ-026 cancel in IDLE or CREDIT with total > 0 -> CHANGE; cancel takes priority over select and over a coin in the same cycle (that coin is rejected).
REQ-027 VEND lasts one cycle, during which the block shall:
- drive drink_valid=1 and drink_out=ID;
- decrement the drink's stock;
- set total to total - price;
- go next to CHANGE if the remainder > 0, else to IDLE.
REQ-028 In CHANGE, each cycle emits the largest denomination in {50,10,5,1} that is <= total, and subtracts it from total; when total reaches 0 the state returns to IDLE.
REQ-029 Change latency equals the greedy coin count. Example: 37 -> 10, 10, 10, 5, 1, 1 over 6 cycles.
REQ-030 restock is honoured only in IDLE; it is ignored in other states.
REQ-031 Stock shall never wrap below 0; this is guaranteed by REQ-023.
REQ-032 select, coin_valid and restock are ignored in VEND and CHANGE, except that a coin is rejected per REQ-021.

Reset
REQ-033 While reset is high, the block shall hold:
- state = IDLE and total_money = 0;
- all strobes and pulses = 0, with drink_out = 0 and change_coin = 0;
- every stock counter = INIT_STOCK, so sold_out = 0.
REQ-034 Reset mid-operation discards any credit and any undispensed change without refund; the first edge after reset deassertion operates from IDLE.

Structure
REQ-035 Package vend_pkg holds the state enum, the coin denomination constants, and a greedy next-coin function.
REQ-036 The CHANGE datapath is a sub-module change_dispenser: load a value, then emit one coin per cycle, then signal done.

Verification
REQ-037 Insert 10, 5, 10 in IDLE; select 4 -> select_nak; insert 10, then select 4 -> drink 4 out, change_coin 10 in the next cycle, then IDLE.
REQ-038 Insert 50, then cancel -> one change_coin 50, total 0, IDLE; a coin_value of 7 -> coin_reject, total unchanged.
REQ-039 Buy drink 1 (price 10) 5 times with exact coins -> sold_out[0]=1; a sixth select 1 -> select_nak; restock in IDLE -> sold_out[0]=0.
REQ-040 Credit 50+50+50+50 = 200; a further 1 -> coin_reject; select 3 -> change sequence 50, 50, 50, 10, 10, 10.
REQ-041 Select 2 and insert 10 in the same cycle with total 10 -> select_nak and total 20.
REQ-042 Assert reset during CHANGE with 36 remaining -> immediately IDLE, total 0, no further change_valid.
